// File: rtl/tnoc_pkg.sv
// Shared router types: configuration record, width helpers and the
// output-buffer entry carried between the switch and its FIFO.
package tnoc_pkg;

    typedef struct packed {
        logic [7:0]  virtual_channels;
        logic [15:0] data_width;
    } tnoc_config;

    localparam tnoc_config TNOC_DEFAULT_CONFIG = '{
        virtual_channels: 8'd2,
        data_width:       16'd32
    };

    localparam int TNOC_PORTS = 5;

    // Flit payload width for a given router configuration
    function automatic int tnoc_flit_width(tnoc_config cfg);
        return int'(cfg.data_width);
    endfunction

    // VC index width, never narrower than one bit
    function automatic int tnoc_vc_width(int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    localparam int TNOC_FLIT_WIDTH = tnoc_flit_width(TNOC_DEFAULT_CONFIG);
    localparam int TNOC_VC_WIDTH   = tnoc_vc_width(int'(TNOC_DEFAULT_CONFIG.virtual_channels));

    typedef struct packed {
        logic [TNOC_FLIT_WIDTH-1:0] flit;
        logic [TNOC_VC_WIDTH-1:0]   vc;
        logic                       last;
    } tnoc_output_entry;

endpackage

// File: rtl/tnoc_fifo.sv
// Small synchronous FIFO with first-word fall-through read data.
module tnoc_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full
);

    localparam int PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_WIDTH = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]     r_mem [DEPTH];
    logic [PTR_WIDTH-1:0] r_wr_ptr;
    logic [PTR_WIDTH-1:0] r_rd_ptr;
    logic [CNT_WIDTH-1:0] r_count;
    logic                 w_do_push;
    logic                 w_do_pop;

    function automatic logic [PTR_WIDTH-1:0] next_ptr(logic [PTR_WIDTH-1:0] ptr);
        return (ptr == PTR_WIDTH'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_WIDTH'(DEPTH));
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Storage array; contents are meaningless until written, so no reset
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/tnoc_output_switch.sv
// Router output stage: switches the granted input port into a 2-entry
// buffer and forwards flits downstream under per-VC credit control.
module tnoc_output_switch
    import tnoc_pkg::*;
#(
    parameter  tnoc_config CONFIG     = TNOC_DEFAULT_CONFIG,
    parameter  int         CREDITS    = 4,
    localparam int         CHANNELS   = int'(CONFIG.virtual_channels),
    localparam int         FLIT_WIDTH = tnoc_flit_width(CONFIG),
    localparam int         VC_WIDTH   = tnoc_vc_width(CHANNELS)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [TNOC_PORTS-1:0]                i_output_grant,
    output logic                                 o_output_free,
    output logic [CHANNELS-1:0]                  o_vc_available,
    input  logic [TNOC_PORTS-1:0]                i_valid,
    output logic [TNOC_PORTS-1:0]                o_ready,
    input  logic [TNOC_PORTS-1:0][FLIT_WIDTH-1:0] i_flit,
    input  logic [TNOC_PORTS-1:0][VC_WIDTH-1:0]  i_vc,
    input  logic [TNOC_PORTS-1:0]                i_last,
    output logic                                 o_valid,
    output logic [FLIT_WIDTH-1:0]                o_flit,
    output logic [VC_WIDTH-1:0]                  o_vc,
    output logic                                 o_last,
    input  logic [CHANNELS-1:0]                  i_credit_return
);

    localparam int CNT_WIDTH   = $clog2(CREDITS + 1);
    localparam int ENTRY_WIDTH = $bits(tnoc_output_entry);

    tnoc_output_entry        w_in_entry;
    tnoc_output_entry        w_head;
    logic                    w_grant_held;
    logic                    w_accept;
    logic                    w_pop;
    logic                    w_buf_full;
    logic                    w_buf_empty;
    logic [CHANNELS-1:0]     w_vc_available;

    logic                    r_packet_done;
    logic                    r_in_packet;
    logic [TNOC_PORTS-1:0]   r_prev_grant;
    logic                    r_output_free;
    logic                    r_valid;
    logic [FLIT_WIDTH-1:0]   r_flit;
    logic [VC_WIDTH-1:0]     r_vc;
    logic                    r_last;

    // The controller keeps the old grant for one cycle after a tail;
    // block it until the grant changes or drops so the next packet
    // cannot slip in under the stale grant.
    assign w_grant_held = r_packet_done && (i_output_grant == r_prev_grant);
    assign o_ready      = (w_grant_held || w_buf_full) ? '0 : i_output_grant;
    assign w_accept     = |(i_valid & o_ready);

    // Grant-driven mux of the selected input's flit fields
    always_comb begin
        w_in_entry = '0;
        for (int j = 0; j < TNOC_PORTS; j++) begin
            if (i_output_grant[j]) begin
                w_in_entry.flit = i_flit[j];
                w_in_entry.vc   = i_vc[j];
                w_in_entry.last = i_last[j];
            end
        end
    end

    tnoc_fifo #(
        .WIDTH (ENTRY_WIDTH),
        .DEPTH (2)
    ) u_output_buffer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_accept),
        .i_pop   (w_pop),
        .i_data  (w_in_entry),
        .o_data  (w_head),
        .o_empty (w_buf_empty),
        .o_full  (w_buf_full)
    );

    assign w_pop          = !w_buf_empty && w_vc_available[w_head.vc];
    assign o_vc_available = w_vc_available;

    for (genvar v = 0; v < CHANNELS; v++) begin : g_credit
        logic                 w_dec;
        logic                 w_inc;
        logic [CNT_WIDTH-1:0] r_count;

        assign w_dec             = w_pop && (w_head.vc == VC_WIDTH'(v));
        assign w_inc             = i_credit_return[v];
        assign w_vc_available[v] = (r_count != '0);

        // Per-VC credit counter; a coincident send and return cancel out
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_count <= CNT_WIDTH'(CREDITS);
            end else if (w_inc && !w_dec) begin
                if (r_count != CNT_WIDTH'(CREDITS)) begin
                    r_count <= r_count + 1'b1;
                end
            end else if (w_dec && !w_inc) begin
                r_count <= r_count - 1'b1;
            end
        end

        a_credit_overflow: assert property (@(posedge clk) disable iff (!rst_n)
            !(w_inc && !w_dec && (r_count == CNT_WIDTH'(CREDITS))));
    end

    // Packet framing: tail tracking for the held-grant gate and the free pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_packet_done <= 1'b0;
            r_in_packet   <= 1'b0;
            r_prev_grant  <= '0;
            r_output_free <= 1'b0;
        end else begin
            r_prev_grant  <= i_output_grant;
            r_output_free <= w_accept && w_in_entry.last;
            if (w_accept && w_in_entry.last) begin
                r_packet_done <= 1'b1;
            end else if ((i_output_grant == '0) || (i_output_grant != r_prev_grant)) begin
                r_packet_done <= 1'b0;
            end
            if (w_accept) begin
                r_in_packet <= !w_in_entry.last;
            end
        end
    end

    // Registered send stage; payload holds its last value when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_flit  <= '0;
            r_vc    <= '0;
            r_last  <= 1'b0;
        end else if (w_pop) begin
            r_valid <= 1'b1;
            r_flit  <= w_head.flit;
            r_vc    <= w_head.vc;
            r_last  <= w_head.last;
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign o_output_free = r_output_free;
    assign o_valid       = r_valid;
    assign o_flit        = r_flit;
    assign o_vc          = r_vc;
    assign o_last        = r_last;

    a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(i_output_grant));

    a_grant_stable: assert property (@(posedge clk) disable iff (!rst_n)
        r_in_packet |-> (i_output_grant == r_prev_grant));

    a_vc_range: assert property (@(posedge clk) disable iff (!rst_n)
        w_accept |-> (32'(w_in_entry.vc) < CHANNELS));

endmodule

// File: tb/tb_tnoc_output_switch.sv
// Randomized bench for tnoc_output_switch against a queue-based model.
module tb_tnoc_output_switch;
    import tnoc_pkg::*;

    localparam int PORTS   = 5;
    localparam int CH      = 2;
    localparam int CREDITS = 4;
    localparam int FW      = tnoc_flit_width(TNOC_DEFAULT_CONFIG);

    typedef struct {
        logic [FW-1:0] flit;
        logic          vc;
        logic          last;
    } ent_t;

    logic                        clk = 1'b0;
    logic                        rst_n = 1'b0;
    logic [PORTS-1:0]            i_output_grant;
    logic                        o_output_free;
    logic [CH-1:0]               o_vc_available;
    logic [PORTS-1:0]            i_valid;
    logic [PORTS-1:0]            o_ready;
    logic [PORTS-1:0][FW-1:0]    i_flit;
    logic [PORTS-1:0][0:0]       i_vc;
    logic [PORTS-1:0]            i_last;
    logic                        o_valid;
    logic [FW-1:0]               o_flit;
    logic [0:0]                  o_vc;
    logic                        o_last;
    logic [CH-1:0]               i_credit_return;

    logic [PORTS-1:0]            drvGrant;
    logic [PORTS-1:0]            drvValid;
    logic [PORTS-1:0][FW-1:0]    drvFlit;
    logic [PORTS-1:0][0:0]       drvVc;
    logic [PORTS-1:0]            drvLast;
    logic [CH-1:0]               drvRet;
    int                          retMode;

    ent_t                        mq[$];
    int                          mCredit [CH];
    bit                          mPktDone;
    logic [PORTS-1:0]            mPrevGrant;
    bit                          mAccept;
    bit                          expValid;
    bit                          expFree;
    logic [FW-1:0]               expFlit;
    logic                        expVc;
    logic                        expLast;

    int                          testCount = 0;
    int                          failCount = 0;

    always #5 clk = ~clk;

    tnoc_output_switch #(
        .CONFIG  (TNOC_DEFAULT_CONFIG),
        .CREDITS (CREDITS)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_output_grant  (i_output_grant),
        .o_output_free   (o_output_free),
        .o_vc_available  (o_vc_available),
        .i_valid         (i_valid),
        .o_ready         (o_ready),
        .i_flit          (i_flit),
        .i_vc            (i_vc),
        .i_last          (i_last),
        .o_valid         (o_valid),
        .o_flit          (o_flit),
        .o_vc            (o_vc),
        .o_last          (o_last),
        .i_credit_return (i_credit_return)
    );

    // Single comparison point for every check in the bench
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        for (int v = 0; v < CH; v++) mCredit[v] = CREDITS;
        mPktDone   = 1'b0;
        mPrevGrant = '0;
        mAccept    = 1'b0;
        expValid   = 1'b0;
        expFree    = 1'b0;
        expFlit    = '0;
        expVc      = 1'b0;
        expLast    = 1'b0;
    endtask

    task automatic zeroInputs();
        drvGrant = '0; drvValid = '0; drvFlit = '0; drvVc = '0; drvLast = '0; drvRet = '0;
        i_output_grant = '0; i_valid = '0; i_flit = '0; i_vc = '0; i_last = '0;
        i_credit_return = '0;
    endtask

    task automatic randomNoise();
        drvValid = PORTS'($urandom);
        drvLast  = PORTS'($urandom);
        for (int k = 0; k < PORTS; k++) begin
            drvFlit[k] = FW'($urandom);
            drvVc[k]   = 1'($urandom);
        end
    endtask

    // One clock cycle: check registered outputs, drive, check ready/credit view, advance model
    task automatic applyStimulus();
        bit               pop;
        int               popVc;
        int               sel;
        logic [PORTS-1:0] ready;
        ent_t             e;
        @(negedge clk);
        checkOutput("o_valid", o_valid, expValid);
        checkOutput("o_output_free", o_output_free, expFree);
        checkOutput("o_flit", o_flit, expFlit);
        checkOutput("o_vc", o_vc, expVc);
        checkOutput("o_last", o_last, expLast);
        pop   = (mq.size() > 0) && (mCredit[mq[0].vc] > 0);
        popVc = pop ? int'(mq[0].vc) : -1;
        if (retMode == 0) begin
            drvRet = '0;
        end else if (retMode == 1) begin
            for (int v = 0; v < CH; v++)
                drvRet[v] = ($urandom_range(0, 2) == 0) && ((mCredit[v] < CREDITS) || (popVc == v));
        end else if (retMode == 3) begin
            drvRet = {(popVc == 1) && (mCredit[1] == 2), 1'b0};
        end
        i_output_grant  = drvGrant;
        i_valid         = drvValid;
        i_flit          = drvFlit;
        i_vc            = drvVc;
        i_last          = drvLast;
        i_credit_return = drvRet;
        #1;
        ready = ((mPktDone && (drvGrant == mPrevGrant)) || (mq.size() == 2)) ? '0 : drvGrant;
        checkOutput("o_ready", o_ready, ready);
        checkOutput("o_vc_available", o_vc_available, {mCredit[1] != 0, mCredit[0] != 0});
        sel = -1;
        for (int j = 0; j < PORTS; j++) if (drvGrant[j]) sel = j;
        mAccept = (sel >= 0) && ready[sel] && drvValid[sel];
        expFree = mAccept && drvLast[sel];
        if (pop) begin
            e = mq.pop_front();
            expValid = 1'b1;
            expFlit  = e.flit;
            expVc    = e.vc;
            expLast  = e.last;
            mCredit[e.vc]--;
        end else begin
            expValid = 1'b0;
        end
        for (int v = 0; v < CH; v++)
            if (drvRet[v] && (mCredit[v] < CREDITS)) mCredit[v]++;
        if (mAccept) mq.push_back('{drvFlit[sel], drvVc[sel][0], drvLast[sel]});
        if (expFree) mPktDone = 1'b1;
        else if ((drvGrant == '0) || (drvGrant != mPrevGrant)) mPktDone = 1'b0;
        mPrevGrant = drvGrant;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        zeroInputs();
        #1;
        checkOutput("rst_o_valid", o_valid, 1'b0);
        checkOutput("rst_o_output_free", o_output_free, 1'b0);
        checkOutput("rst_o_vc_available", o_vc_available, 2'b11);
        checkOutput("rst_o_flit", o_flit, '0);
        checkOutput("rst_o_ready", o_ready, '0);
        @(negedge clk);
        rst_n = 1'b1;
        modelReset();
    endtask

    task automatic idleCycles(input int n);
        drvGrant = '0;
        drvValid = '0;
        repeat (n) applyStimulus();
    endtask

    task automatic gapCycle();
        drvGrant = '0;
        randomNoise();
        applyStimulus();
    endtask

    // Offer one packet on a port under a steady grant, then the held-over cycle
    task automatic sendPacket(input int port, input int len, input int vc);
        int sent = 0;
        int cycles = 0;
        drvGrant = PORTS'(1) << port;
        while (sent < len && cycles < 100) begin
            randomNoise();
            drvValid[port] = ($urandom_range(0, 3) != 0);
            drvVc[port]    = 1'(vc);
            drvLast[port]  = (sent == len - 1);
            applyStimulus();
            if (mAccept) sent++;
            cycles++;
        end
        if (sent < len) begin
            checkOutput("pkt_timeout", sent, len);
        end else begin
            randomNoise();
            drvValid[port] = 1'b1;
            drvVc[port]    = 1'(vc);
            drvLast[port]  = 1'b0;
            applyStimulus();
            checkOutput("held_ready", o_ready[port], 1'b0);
        end
    endtask

    initial begin
        int lastPort;
        int port;
        int k;
        zeroInputs();
        retMode = 0;
        modelReset();

        // Single three-flit packet on port 2, VC 1
        doReset();
        sendPacket(2, 3, 1);
        idleCycles(5);
        checkOutput("single_vc_avail", o_vc_available, 2'b11);

        // Credit stall: five single-flit packets on VC 0 without returns
        doReset();
        for (int p = 0; p < 5; p++) begin
            sendPacket(0, 1, 0);
            gapCycle();
        end
        idleCycles(4);
        checkOutput("stall_vc_avail", o_vc_available, 2'b10);
        retMode  = 2;
        drvGrant = '0;
        drvValid = '0;
        drvRet   = 2'b01;
        applyStimulus();
        drvRet   = 2'b00;
        applyStimulus();
        retMode  = 0;
        idleCycles(3);
        checkOutput("stall_drained_avail", o_vc_available, 2'b10);

        // Fill the buffer on stalled VC 0, then reset mid-packet
        drvGrant = 5'b00010;
        k = 0;
        while (mq.size() < 2 && k < 10) begin
            drvValid = 5'b00010;
            drvVc    = '0;
            drvLast  = '0;
            drvFlit[1] = FW'($urandom);
            applyStimulus();
            k++;
        end
        @(negedge clk);
        i_valid = '0;
        #1;
        checkOutput("full_ready", o_ready, '0);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_o_valid", o_valid, 1'b0);
        checkOutput("midrst_o_output_free", o_output_free, 1'b0);
        checkOutput("midrst_vc_avail", o_vc_available, 2'b11);
        checkOutput("midrst_ready_empty", o_ready, 5'b00010);
        zeroInputs();
        @(negedge clk);
        rst_n = 1'b1;
        modelReset();
        idleCycles(2);

        // Back-to-back packets from ports 0 and 4 with a direct grant switch
        retMode = 1;
        sendPacket(0, 3, 0);
        sendPacket(4, 2, 1);
        gapCycle();
        idleCycles(6);

        // Randomized packet traffic with random legal credit returns
        lastPort = -1;
        for (int p = 0; p < 40; p++) begin
            port = $urandom_range(0, PORTS - 1);
            if (port == lastPort || $urandom_range(0, 1) == 1) gapCycle();
            sendPacket(port, $urandom_range(1, 4), $urandom_range(0, CH - 1));
            lastPort = port;
        end
        idleCycles(20);

        // Coincident send and return on VC 1 at two credits leaves two
        doReset();
        retMode = 3;
        sendPacket(3, 3, 1);
        idleCycles(5);
        retMode = 0;
        gapCycle();
        sendPacket(3, 2, 1);
        idleCycles(5);
        checkOutput("pop_ret_vc_avail", o_vc_available, 2'b01);

        $display("End of test - %0d assertions evaluated, %0d failures", testCount, failCount);
        $finish;
    end

endmodule
